// File: rtl/execution_tb_ace_sram_rd_ctrl.sv
// SRAM read controller: turns unpacked address beats into single-cycle SRAM reads and
// returns the data, in acceptance order, on an ACE R channel through a 4-entry FIFO.
module execution_tb_ace_sram_rd_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_AW     = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] unpk_addr_i,
  input  logic                  unpk_last_i,
  input  logic                  unpk_valid_i,
  output logic                  unpk_ready_o,
  output logic                  sram_cs_o,
  output logic [MEM_AW-1:0]     sram_addr_o,
  input  logic [63:0]           sram_rdata_i,
  output logic [63:0]           ace_rdata_o,
  output logic [1:0]            ace_rresp_o,
  output logic                  ace_rlast_o,
  output logic                  ace_rvalid_o,
  input  logic                  ace_rready_i
);

  localparam int unsigned Depth = 4;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t      mem_q [Depth];
  beat_t      push_beat;
  beat_t      head;
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q, count_d;
  logic       inflight_q, infl_last_q, infl_in_range_q;
  logic [1:0] infl_resp_q;
  logic       accept, in_range, push, pop;
  logic       unused_addr_lsb;

  assign unused_addr_lsb = ^unpk_addr_i[2:0];

  // Outstanding beats = buffered + the one whose SRAM data arrives this cycle.
  assign unpk_ready_o = ({1'b0, count_q} + {3'b000, inflight_q}) < 4'd4;
  assign accept       = unpk_valid_i & unpk_ready_o;
  assign in_range     = (unpk_addr_i[ADDR_WIDTH-1:MEM_AW+3] == '0);
  assign sram_cs_o    = accept & in_range;
  assign sram_addr_o  = unpk_addr_i[MEM_AW+2:3];

  assign push = inflight_q;
  assign pop  = ace_rvalid_o & ace_rready_i;

  assign push_beat.data = infl_in_range_q ? sram_rdata_i : 64'h0;
  assign push_beat.resp = infl_resp_q;
  assign push_beat.last = infl_last_q;

  assign head         = mem_q[rd_ptr_q];
  assign ace_rvalid_o = (count_q != 3'd0);
  assign ace_rdata_o  = head.data;
  assign ace_rresp_o  = head.resp;
  assign ace_rlast_o  = head.last;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q      <= 1'b0;
      infl_last_q     <= 1'b0;
      infl_resp_q     <= 2'b00;
      infl_in_range_q <= 1'b0;
    end else begin
      inflight_q <= accept;
      if (accept) begin
        infl_last_q     <= unpk_last_i;
        infl_resp_q     <= in_range ? 2'b00 : 2'b10;
        infl_in_range_q <= in_range;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= push_beat;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
    end
  end

  // Ready accounting guarantees a free slot for every in-flight read.
  no_overflow_a: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && count_q == 3'd4));

endmodule

// File: tb/tb_execution_tb_ace_sram_rd_ctrl.sv
// Bench for execution_tb_ace_sram_rd_ctrl: directed beats, an in-order expected-beat queue
// as reference model, and a per-cycle comparison of all outputs against it.
module tb_execution_tb_ace_sram_rd_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned MAW = 14;

  logic           clk;
  logic           reset_n;
  logic [AW-1:0]  unpk_addr_i;
  logic           unpk_last_i;
  logic           unpk_valid_i;
  logic           unpk_ready_o;
  logic           sram_cs_o;
  logic [MAW-1:0] sram_addr_o;
  logic [63:0]    sram_rdata_i;
  logic [63:0]    ace_rdata_o;
  logic [1:0]     ace_rresp_o;
  logic           ace_rlast_o;
  logic           ace_rvalid_o;
  logic           ace_rready_i;

  execution_tb_ace_sram_rd_ctrl #(
    .ADDR_WIDTH(AW),
    .MEM_AW    (MAW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .unpk_addr_i (unpk_addr_i),
    .unpk_last_i (unpk_last_i),
    .unpk_valid_i(unpk_valid_i),
    .unpk_ready_o(unpk_ready_o),
    .sram_cs_o   (sram_cs_o),
    .sram_addr_o (sram_addr_o),
    .sram_rdata_i(sram_rdata_i),
    .ace_rdata_o (ace_rdata_o),
    .ace_rresp_o (ace_rresp_o),
    .ace_rlast_o (ace_rlast_o),
    .ace_rvalid_o(ace_rvalid_o),
    .ace_rready_i(ace_rready_i)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    int          avail;
  } exp_t;
  exp_t model_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] sram_word(input logic [MAW-1:0] w);
    if (w == 14'h21) return 64'hDEAD_BEEF_0123_4567;
    return {16'hC0DE, 2'b00, w, 18'h0, w};
  endfunction

  // SRAM: data appears the cycle after the chip select.
  always @(posedge clk) if (sram_cs_o) sram_rdata_i <= sram_word(sram_addr_o);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: every accepted beat is queued; it is visible two cycles after acceptance
  // and until popped. Outstanding (accepted, not popped) beats are capped at four.
  always @(negedge clk) begin
    logic exp_ready, exp_acc, inr, exp_rvalid;
    exp_t e;
    if (!reset_n) begin
      model_q.delete();
      chk("rst_rvalid", ace_rvalid_o, 0);
      chk("rst_rdata", ace_rdata_o, 0);
      chk("rst_rresp", ace_rresp_o, 0);
      chk("rst_rlast", ace_rlast_o, 0);
      chk("rst_ready", unpk_ready_o, 1);
      chk("rst_cs", sram_cs_o, 0);
    end else begin
      exp_ready = (model_q.size() < 4);
      exp_acc   = unpk_valid_i && exp_ready;
      inr       = (unpk_addr_i[AW-1:MAW+3] == 0);
      chk("ready", unpk_ready_o, exp_ready);
      chk("cs", sram_cs_o, exp_acc && inr);
      if (exp_acc && inr) chk("sram_addr", sram_addr_o, unpk_addr_i[MAW+2:3]);
      exp_rvalid = (model_q.size() != 0) && (model_q[0].avail <= cyc);
      chk("rvalid", ace_rvalid_o, exp_rvalid);
      if (exp_rvalid) begin
        chk("rdata", ace_rdata_o, model_q[0].data);
        chk("rresp", ace_rresp_o, model_q[0].resp);
        chk("rlast", ace_rlast_o, model_q[0].last);
        if (ace_rready_i) void'(model_q.pop_front());
      end
      if (exp_acc) begin
        e.data  = inr ? sram_word(unpk_addr_i[MAW+2:3]) : 64'h0;
        e.resp  = inr ? 2'b00 : 2'b10;
        e.last  = unpk_last_i;
        e.avail = cyc + 2;
        model_q.push_back(e);
      end
    end
    cyc++;
  end

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  // Called at a drive point; holds the beat for up to `bound` cycles.
  task automatic offer(input logic [31:0] addr, input logic last, input int bound,
                       output bit acc, output logic cs, output logic [MAW-1:0] a);
    unpk_valid_i = 1'b1;
    unpk_addr_i  = addr;
    unpk_last_i  = last;
    acc = 0;
    cs  = 0;
    a   = '0;
    for (int i = 0; i < bound && !acc; i++) begin
      @(negedge clk);
      acc = unpk_ready_o;
      cs  = sram_cs_o;
      a   = sram_addr_o;
      to_drive();
    end
    unpk_valid_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    int i = 0;
    while (model_q.size() != 0 && i < budget) begin
      to_drive();
      i++;
    end
    chk("drain_done", model_q.size(), 0);
  endtask

  initial begin
    bit acc;
    logic cs;
    logic [MAW-1:0] a;
    int n;
    reset_n      = 1'b1;
    unpk_valid_i = 1'b0;
    unpk_addr_i  = '0;
    unpk_last_i  = 1'b0;
    ace_rready_i = 1'b1;
    sram_rdata_i = '0;
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk("lit_rst_ready", unpk_ready_o, 1);
    chk("lit_rst_rvalid", ace_rvalid_o, 0);
    repeat (2) to_drive();
    reset_n = 1'b1;
    to_drive();

    // Single beat
    offer(32'h0000_0108, 1'b1, 1, acc, cs, a);
    chk("lit_single_acc", acc, 1);
    chk("lit_single_cs", cs, 1);
    chk("lit_single_addr", a, 14'h21);
    @(negedge clk);
    chk("lit_single_n1_rvalid", ace_rvalid_o, 0);
    @(negedge clk);
    chk("lit_single_rvalid", ace_rvalid_o, 1);
    chk("lit_single_rdata", ace_rdata_o, 64'hDEAD_BEEF_0123_4567);
    chk("lit_single_rresp", ace_rresp_o, 0);
    chk("lit_single_rlast", ace_rlast_o, 1);
    to_drive();
    drain(10);

    // Four-beat burst, consecutive cycles
    for (int i = 0; i < 4; i++) begin
      offer(32'h0000_1000 + 32'(8 * i), (i == 3), 1, acc, cs, a);
      chk("lit_burst_acc", acc, 1);
      chk("lit_burst_addr", a, 14'h200 + 14'(i));
    end
    drain(10);

    // Out of range
    offer(32'h0002_0000, 1'b1, 1, acc, cs, a);
    chk("lit_oor_acc", acc, 1);
    chk("lit_oor_cs", cs, 0);
    @(negedge clk);
    @(negedge clk);
    chk("lit_oor_rvalid", ace_rvalid_o, 1);
    chk("lit_oor_rdata", ace_rdata_o, 0);
    chk("lit_oor_rresp", ace_rresp_o, 2'b10);
    chk("lit_oor_rlast", ace_rlast_o, 1);
    to_drive();
    drain(10);

    // Backpressure: six offered, four accepted
    ace_rready_i = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      offer(32'h0000_2000 + 32'(8 * i), (i == 5), 1, acc, cs, a);
      n += int'(acc);
    end
    chk("lit_bp_accepted", n, 4);
    @(negedge clk);
    chk("lit_bp_ready", unpk_ready_o, 0);
    to_drive();
    ace_rready_i = 1'b1;
    drain(20);

    // Full FIFO, then streaming with pops at count 4 and pointer wrap, mixed ranges
    ace_rready_i = 1'b0;
    for (int i = 0; i < 4; i++) offer(32'h0000_3000 + 32'(8 * i), 1'b0, 1, acc, cs, a);
    ace_rready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer((i % 4 == 2) ? 32'h0010_0000 + 32'(8 * i) : 32'h0000_3100 + 32'(8 * i),
            (i % 3 == 2), 4, acc, cs, a);
      chk("lit_stream_acc", acc, 1);
      ace_rready_i = (i % 3 != 0);
    end
    ace_rready_i = 1'b1;
    drain(20);

    // Reset with three beats buffered
    ace_rready_i = 1'b0;
    for (int i = 0; i < 3; i++) offer(32'h0000_4000 + 32'(8 * i), (i == 2), 1, acc, cs, a);
    repeat (2) to_drive();
    reset_n = 1'b0;
    #1;
    chk("lit_midrst_rvalid", ace_rvalid_o, 0);
    chk("lit_midrst_ready", unpk_ready_o, 1);
    repeat (2) to_drive();
    reset_n = 1'b1;
    ace_rready_i = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      n += int'(ace_rvalid_o);
    end
    chk("lit_no_stale", n, 0);
    to_drive();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
